// File: rtl/cci_mpf_shim_buffer_rx_lockstep.sv
// Lockstep Rx buffer: captures FIU c0/c1 responses into one show-ahead FIFO and
// throttles the AFU Tx path using conservative per-request buffer credits.
module cci_mpf_shim_buffer_rx_lockstep #(
    parameter int unsigned N_ENTRIES = 64,
    parameter int unsigned THRESHOLD = 8,
    parameter int unsigned C0RX_BITS = 64,
    parameter int unsigned C1RX_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [C0RX_BITS-1:0] fiu_c0Rx,
    input  logic                 fiu_c0Rx_valid,
    input  logic [C1RX_BITS-1:0] fiu_c1Rx,
    input  logic                 fiu_c1Rx_valid,

    input  logic                 tx_c0_issue,
    input  logic                 tx_c1_issue,

    output logic [C0RX_BITS-1:0] afu_c0Rx,
    output logic                 afu_c0Rx_valid,
    output logic [C1RX_BITS-1:0] afu_c1Rx,
    output logic                 afu_c1Rx_valid,
    input  logic                 deqRx,
    output logic                 rxNotEmpty,

    output logic                 txAlmFull,
    output logic                 overflow,
    output logic                 credit_err
);

    localparam int unsigned CNT_W = $clog2(N_ENTRIES + 1);
    localparam int unsigned PTR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    // Reserve room for two issues per cycle over THRESHOLD cycles plus the register lag.
    localparam int ALM_LEVEL = int'(N_ENTRIES) - 2 * (int'(THRESHOLD) + 1);

    // Storage (intentionally not reset)
    logic [C0RX_BITS-1:0] r_c0_mem [N_ENTRIES];
    logic [C1RX_BITS-1:0] r_c1_mem [N_ENTRIES];
    logic [N_ENTRIES-1:0] r_c0v_mem;
    logic [N_ENTRIES-1:0] r_c1v_mem;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reserved;
    logic             r_txalm;
    logic             r_overflow;
    logic             r_credit_err;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_reserved_next;
    logic             w_txalm_next;
    logic             w_credit_fault;

    logic w_enq;
    logic w_not_empty;
    logic w_full;
    logic w_deq;
    logic w_push;
    logic w_drop;
    logic w_head_c0v;
    logic w_head_c1v;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_enq       = fiu_c0Rx_valid | fiu_c1Rx_valid;
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(N_ENTRIES));
    assign w_deq       = deqRx & w_not_empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push      = w_enq & (~w_full | w_deq);
    assign w_drop      = w_enq & w_full & ~w_deq;

    assign w_head_c0v  = r_c0v_mem[r_rd_ptr];
    assign w_head_c1v  = r_c1v_mem[r_rd_ptr];

    always_comb begin
        w_wr_ptr_next = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_next = w_deq ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_count_next  = r_count;
        unique case ({w_push, w_deq})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        int v_sum;
        v_sum = int'(r_reserved) + int'(tx_c0_issue) + int'(tx_c1_issue);
        if (w_deq) begin
            v_sum = v_sum - int'(w_head_c0v) - int'(w_head_c1v);
        end
        w_credit_fault  = 1'b0;
        w_reserved_next = '0;
        if (v_sum < 0) begin
            w_credit_fault = 1'b1;
        end else if (v_sum > int'(N_ENTRIES)) begin
            w_credit_fault  = 1'b1;
            w_reserved_next = CNT_W'(N_ENTRIES);
        end else begin
            w_reserved_next = CNT_W'(v_sum);
        end
        w_txalm_next = (int'(w_reserved_next) >= ALM_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_c0_mem[r_wr_ptr]  <= fiu_c0Rx;
            r_c1_mem[r_wr_ptr]  <= fiu_c1Rx;
            r_c0v_mem[r_wr_ptr] <= fiu_c0Rx_valid;
            r_c1v_mem[r_wr_ptr] <= fiu_c1Rx_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_reserved   <= '0;
            r_txalm      <= 1'b0;
            r_overflow   <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            r_reserved   <= w_reserved_next;
            r_txalm      <= w_txalm_next;
            r_overflow   <= r_overflow | w_drop;
            r_credit_err <= r_credit_err | w_credit_fault;
        end
    end

    // Payloads are masked so nothing stale leaks out while empty or in reset.
    assign afu_c0Rx       = w_not_empty ? r_c0_mem[r_rd_ptr] : '0;
    assign afu_c1Rx       = w_not_empty ? r_c1_mem[r_rd_ptr] : '0;
    assign afu_c0Rx_valid = w_head_c0v & w_not_empty;
    assign afu_c1Rx_valid = w_head_c1v & w_not_empty;
    assign rxNotEmpty     = w_not_empty;
    assign txAlmFull      = r_txalm;
    assign overflow       = r_overflow;
    assign credit_err     = r_credit_err;

endmodule

// File: tb/tb_cci_mpf_shim_buffer_rx_lockstep.sv
// Bench for the lockstep Rx buffer: directed corner cases plus random traffic,
// all checked against a queue-based reference model.
module tb_cci_mpf_shim_buffer_rx_lockstep;

    localparam int N  = 8;
    localparam int TH = 1;
    localparam int W  = 8;
    localparam int ALM_LEVEL = N - 2 * (TH + 1);

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] fiu_c0Rx = '0;
    logic         fiu_c0Rx_valid = 1'b0;
    logic [W-1:0] fiu_c1Rx = '0;
    logic         fiu_c1Rx_valid = 1'b0;
    logic         tx_c0_issue = 1'b0;
    logic         tx_c1_issue = 1'b0;
    logic         deqRx = 1'b0;
    logic [W-1:0] afu_c0Rx;
    logic         afu_c0Rx_valid;
    logic [W-1:0] afu_c1Rx;
    logic         afu_c1Rx_valid;
    logic         rxNotEmpty;
    logic         txAlmFull;
    logic         overflow;
    logic         credit_err;

    cci_mpf_shim_buffer_rx_lockstep #(
        .N_ENTRIES(N),
        .THRESHOLD(TH),
        .C0RX_BITS(W),
        .C1RX_BITS(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fiu_c0Rx(fiu_c0Rx),
        .fiu_c0Rx_valid(fiu_c0Rx_valid),
        .fiu_c1Rx(fiu_c1Rx),
        .fiu_c1Rx_valid(fiu_c1Rx_valid),
        .tx_c0_issue(tx_c0_issue),
        .tx_c1_issue(tx_c1_issue),
        .afu_c0Rx(afu_c0Rx),
        .afu_c0Rx_valid(afu_c0Rx_valid),
        .afu_c1Rx(afu_c1Rx),
        .afu_c1Rx_valid(afu_c1Rx_valid),
        .deqRx(deqRx),
        .rxNotEmpty(rxNotEmpty),
        .txAlmFull(txAlmFull),
        .overflow(overflow),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p0;
        bit           v0;
        logic [W-1:0] p1;
        bit           v1;
    } ent_t;

    ent_t m_q[$];
    int   m_res;
    bit   m_alm;
    bit   m_ovf;
    bit   m_cerr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_res  = 0;
        m_alm  = 1'b0;
        m_ovf  = 1'b0;
        m_cerr = 1'b0;
    endtask

    // One clock edge of the buffer's rules.
    task automatic model_edge(input bit v0, input logic [W-1:0] p0, input bit v1,
                              input logic [W-1:0] p1, input bit i0, input bit i1, input bit dq);
        ent_t e;
        int   freed;
        bit   was_full;
        freed = 0;
        was_full = (m_q.size() == N);
        if (dq && m_q.size() > 0) begin
            e = m_q.pop_front();
            freed = int'(e.v0) + int'(e.v1);
            was_full = 1'b0;
        end
        if (v0 || v1) begin
            if (was_full) begin
                m_ovf = 1'b1;
            end else begin
                e.p0 = p0; e.v0 = v0; e.p1 = p1; e.v1 = v1;
                m_q.push_back(e);
            end
        end
        m_res = m_res + int'(i0) + int'(i1) - freed;
        if (m_res < 0) begin
            m_res = 0;
            m_cerr = 1'b1;
        end else if (m_res > N) begin
            m_res = N;
            m_cerr = 1'b1;
        end
        m_alm = (m_res >= ALM_LEVEL);
    endtask

    task automatic compare_all();
        bit ne;
        ne = (m_q.size() > 0);
        check_eq("not_empty", 32'(rxNotEmpty), 32'(ne));
        check_eq("c0_valid", 32'(afu_c0Rx_valid), ne ? 32'(m_q[0].v0) : 32'd0);
        check_eq("c1_valid", 32'(afu_c1Rx_valid), ne ? 32'(m_q[0].v1) : 32'd0);
        if (ne && m_q[0].v0) check_eq("c0_data", 32'(afu_c0Rx), 32'(m_q[0].p0));
        if (ne && m_q[0].v1) check_eq("c1_data", 32'(afu_c1Rx), 32'(m_q[0].p1));
        check_eq("alm_full", 32'(txAlmFull), 32'(m_alm));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("credit_err", 32'(credit_err), 32'(m_cerr));
    endtask

    task automatic step(input bit v0, input logic [W-1:0] p0, input bit v1,
                        input logic [W-1:0] p1, input bit i0, input bit i1, input bit dq);
        @(negedge clk);
        fiu_c0Rx_valid = v0; fiu_c0Rx = p0;
        fiu_c1Rx_valid = v1; fiu_c1Rx = p1;
        tx_c0_issue = i0; tx_c1_issue = i1; deqRx = dq;
        @(posedge clk);
        model_edge(v0, p0, v1, p1, i0, i1, dq);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ne"},   32'(rxNotEmpty), 32'd0);
        check_eq({tag, "_v0"},   32'(afu_c0Rx_valid), 32'd0);
        check_eq({tag, "_v1"},   32'(afu_c1Rx_valid), 32'd0);
        check_eq({tag, "_d0"},   32'(afu_c0Rx), 32'd0);
        check_eq({tag, "_d1"},   32'(afu_c1Rx), 32'd0);
        check_eq({tag, "_alm"},  32'(txAlmFull), 32'd0);
        check_eq({tag, "_ovf"},  32'(overflow), 32'd0);
        check_eq({tag, "_cerr"}, 32'(credit_err), 32'd0);
    endtask

    // Asserts reset between clock edges and checks outputs drop before the next edge.
    task automatic reset_pulse();
        @(negedge clk);
        fiu_c0Rx_valid = 1'b0; fiu_c1Rx_valid = 1'b0;
        tx_c0_issue = 1'b0; tx_c1_issue = 1'b0; deqRx = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] head;
        model_reset();
        #12;
        check_all_zero("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single response path
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 8'hA5, 0, 0, 0, 0, 0);
        check_eq("single_c0", 32'(afu_c0Rx), 32'hA5);
        check_eq("single_v1", 32'(afu_c1Rx_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("single_empty", 32'(rxNotEmpty), 32'd0);

        // Lockstep pair
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 8'h11, 1, 8'h22, 0, 0, 0);
        check_eq("pair_v0", 32'(afu_c0Rx_valid), 32'd1);
        check_eq("pair_v1", 32'(afu_c1Rx_valid), 32'd1);
        check_eq("pair_d1", 32'(afu_c1Rx), 32'h22);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("pair_pop", 32'(rxNotEmpty), 32'd0);
        check_eq("pair_cerr", 32'(credit_err), 32'd0);

        // Credit throttle
        reset_pulse();
        step(0, 0, 0, 0, 1, 1, 0);
        check_eq("thr_alm_lo", 32'(txAlmFull), 32'd0);
        step(0, 0, 0, 0, 1, 1, 0);
        check_eq("thr_alm_hi", 32'(txAlmFull), 32'd1);
        step(1, 8'h5A, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("thr_alm_drop", 32'(txAlmFull), 32'd0);

        // Full, enqueue without dequeue
        reset_pulse();
        for (int i = 0; i < N; i++) step(1, W'(8'h40 + i), 0, 0, 1, 0, 0);
        head = afu_c0Rx;
        step(1, 8'hEE, 0, 0, 0, 0, 0);
        check_eq("full_ovf", 32'(overflow), 32'd1);
        check_eq("full_head", 32'(afu_c0Rx), 32'h40);
        check_eq("full_head_same", 32'(afu_c0Rx), 32'(head));

        // Full, enqueue with dequeue
        reset_pulse();
        for (int i = 0; i < N; i++) step(0, 0, 1, W'(8'h80 + i), 0, 1, 0);
        step(0, 0, 1, 8'hC8, 0, 1, 1);
        check_eq("fulldq_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < N; i++) step(0, 0, 0, 0, 0, 0, 1);
        check_eq("fulldq_drained", 32'(rxNotEmpty), 32'd0);

        // Empty corners
        reset_pulse();
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("empty_deq_ne", 32'(rxNotEmpty), 32'd0);
        check_eq("empty_deq_cerr", 32'(credit_err), 32'd0);
        step(1, 8'h77, 0, 0, 0, 0, 1);
        check_eq("empty_enqdeq", 32'(rxNotEmpty), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("unreserved_cerr", 32'(credit_err), 32'd1);

        // Reset mid-run
        reset_pulse();
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, W'(8'h10 + i), 0, 0, 0, 0, 0);
        check_eq("mid_alm", 32'(txAlmFull), 32'd1);
        reset_pulse();
        step(1, 8'h3C, 0, 0, 0, 0, 0);
        check_eq("post_rst_ne", 32'(rxNotEmpty), 32'd1);
        check_eq("post_rst_d0", 32'(afu_c0Rx), 32'h3C);

        // Random traffic
        for (int r = 0; r < 3; r++) begin
            reset_pulse();
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 2) == 0,
                     W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
